// File: rtl/fft_source_capture_if.sv
// Avalon-ST source-side bundle of the FFT core.
//   master : the FFT core (drives valid/sop/eop/error/real/imag, samples ready)
//   slave  : the capture block (samples the beat, drives ready)
interface fft_source_capture_if #(
  parameter int DATA_W = 16
);
  logic              source_valid;
  logic              source_sop;
  logic              source_eop;
  logic [1:0]        source_error;
  logic [DATA_W-1:0] source_real;
  logic [DATA_W-1:0] source_imag;
  logic              source_ready;

  modport master (
    output source_valid, source_sop, source_eop, source_error,
           source_real, source_imag,
    input  source_ready
  );

  modport slave (
    input  source_valid, source_sop, source_eop, source_error,
           source_real, source_imag,
    output source_ready
  );
endinterface

// File: rtl/fft_source_capture.sv
// Captures one FFT output frame (sop..eop) into an internal buffer, checks its
// length against the programmed point count and holds it until acknowledged.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   fftpts_out            expected points per frame, sampled on the sop beat
//   src (slave)           Avalon-ST source stream from the FFT core
//   rd_addr / rd_data     buffer read port, 1-cycle registered latency
//   frame_valid/frame_len held frame present / its point count
//   frame_ack             releases the held frame
//   err_flags / err_clr   sticky {bad fftpts, source_error, sop mid-frame, length}
//   frame_count           good frames captured (wraps)
module fft_source_capture #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W:0]       fftpts_out,
  fft_source_capture_if.slave   src,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [2*DATA_W-1:0]   rd_data,
  output logic                  frame_valid,
  output logic [ADDR_W:0]       frame_len,
  input  logic                  frame_ack,
  output logic [3:0]            err_flags,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      frame_count
);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  localparam logic [ADDR_W:0] MAX_PTS = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     pts_q, pts_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                bad_q, bad_d;
  logic [3:0]          err_q, err_d, err_new;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2*DATA_W-1:0] rd_data_q;
  logic [2*DATA_W-1:0] buf_mem [0:(1<<ADDR_W)-1];

  logic                beat, has_err, pts_ok;
  logic                took, last, we;
  logic [ADDR_W:0]     pos, cur_pts;
  logic                cur_bad;
  logic [ADDR_W-1:0]   waddr;

  assign beat    = src.source_valid & src.source_ready;
  assign has_err = |src.source_error;
  assign pts_ok  = (fftpts_out != '0) && (fftpts_out <= MAX_PTS);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pts_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      bad_q   <= 1'b0;
      err_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pts_q   <= pts_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Buffer has no reset; only the held frame is meaningful.
  always_ff @(posedge clk) begin
    if (we) buf_mem[waddr] <= {src.source_real, src.source_imag};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rd_data_q <= '0;
    else          rd_data_q <= buf_mem[rd_addr];
  end

  // Next-state logic. A sop beat (in IDLE or CAPTURE) always starts a fresh
  // frame at address 0; a non-sop beat only extends a frame in CAPTURE.
  always_comb begin
    state_d = state_q;
    pts_d   = pts_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    bad_d   = bad_q;
    count_d = count_q;
    err_new = '0;
    took    = 1'b0;
    pos     = cnt_q;
    cur_pts = pts_q;
    cur_bad = bad_q;
    last    = 1'b0;
    we      = 1'b0;
    waddr   = '0;

    if (state_q == HOLD) begin
      if (frame_ack) state_d = IDLE;
    end else if (beat) begin
      if (src.source_sop) begin
        if (state_q == CAPTURE) err_new[1] = 1'b1;
        if (!pts_ok) begin
          err_new[3] = 1'b1;
          state_d    = IDLE;
        end else begin
          took    = 1'b1;
          pos     = '0;
          cur_pts = fftpts_out;
          cur_bad = 1'b0;
        end
      end else if (state_q == CAPTURE) begin
        took = 1'b1;
      end
    end

    if (took) begin
      we      = 1'b1;
      waddr   = pos[ADDR_W-1:0];
      cur_bad = cur_bad | has_err;
      if (has_err) err_new[2] = 1'b1;
      pts_d   = cur_pts;
      bad_d   = cur_bad;
      cnt_d   = pos + 1'b1;
      last    = (pos == cur_pts - 1'b1);
      if (src.source_eop) begin
        state_d = IDLE;
        if (!last) err_new[0] = 1'b1;
        else if (!cur_bad) begin
          state_d = HOLD;
          len_d   = cur_pts;
          count_d = count_q + 1'b1;
        end
      end else if (last) begin
        // Frame ran full without eop; trailing beats drop until next sop.
        err_new[0] = 1'b1;
        state_d    = IDLE;
      end else begin
        state_d = CAPTURE;
      end
    end

    // A new error on the clearing edge survives the clear.
    err_d = (err_clr ? 4'b0 : err_q) | err_new;
  end

  // Outputs decoded from registers only
  always_comb begin
    src.source_ready = (state_q != HOLD);
    frame_valid      = (state_q == HOLD);
    frame_len        = len_q;
    err_flags        = err_q;
    frame_count      = count_q;
    rd_data          = rd_data_q;
  end

endmodule

// File: tb/tb_fft_source_capture.sv
module tb_fft_source_capture;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 3;
  localparam int MAXP   = 1 << ADDR_W;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [ADDR_W:0]     fftpts_out = 8;
  logic [ADDR_W-1:0]   rd_addr = '0;
  logic [2*DATA_W-1:0] rd_data;
  logic                frame_valid;
  logic [ADDR_W:0]     frame_len;
  logic                frame_ack = 1'b0;
  logic [3:0]          err_flags;
  logic                err_clr = 1'b0;
  logic [CNT_W-1:0]    frame_count;

  always #5 clk = ~clk;

  fft_source_capture_if #(.DATA_W(DATA_W)) src();

  fft_source_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .fftpts_out(fftpts_out), .src(src),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_valid(frame_valid),
    .frame_len(frame_len), .frame_ack(frame_ack), .err_flags(err_flags),
    .err_clr(err_clr), .frame_count(frame_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a frame is a queue of samples; the held frame is a copy.
  bit               m_hold, m_in, m_bad;
  int               m_pts;
  logic [31:0]      cur[$];
  logic [31:0]      held[$];
  logic [3:0]       m_err;
  logic [CNT_W-1:0] m_cnt;
  logic [ADDR_W:0]  m_len;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check ready, clock, update model, check outputs.
  task automatic step(input bit v, input bit s, input bit e, input logic [1:0] er,
                      input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                      input bit ack, input bit clr);
    bit was_hold, took;
    logic [3:0] ne;
    int n, ra;
    src.source_valid = v; src.source_sop = s; src.source_eop = e;
    src.source_error = er; src.source_real = re; src.source_imag = im;
    frame_ack = ack; err_clr = clr;
    ra = int'(rd_addr);
    was_hold = m_hold;
    chk("source_ready", src.source_ready, !m_hold);
    @(posedge clk);
    ne = '0; took = 0;
    if (v && !was_hold) begin
      if (s) begin
        if (m_in) ne[1] = 1'b1;
        if (fftpts_out == 0 || fftpts_out > MAXP) begin
          ne[3] = 1'b1; m_in = 0;
        end else begin
          cur.delete(); cur.push_back({re, im});
          m_pts = int'(fftpts_out); m_bad = 0; took = 1;
        end
      end else if (m_in) begin
        cur.push_back({re, im}); took = 1;
      end
      if (took) begin
        m_in = 1;
        if (er != 0) begin ne[2] = 1'b1; m_bad = 1; end
        n = cur.size();
        if (e) begin
          m_in = 0;
          if (n != m_pts) ne[0] = 1'b1;
          else if (!m_bad) begin
            m_hold = 1; held = cur; m_len = (ADDR_W+1)'(m_pts); m_cnt++;
          end
        end else if (n == m_pts) begin
          ne[0] = 1'b1; m_in = 0;
        end
      end
    end
    if (was_hold && ack) m_hold = 0;
    m_err = (clr ? 4'b0 : m_err) | ne;
    #1;
    chk("err_flags", err_flags, m_err);
    chk("frame_valid", frame_valid, m_hold);
    chk("frame_count", frame_count, m_cnt);
    chk("frame_len", frame_len, m_len);
    if (was_hold && ra < held.size()) chk("rd_data_hold", rd_data, held[ra]);
  endtask

  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 2'b00, DATA_W'($urandom), DATA_W'($urandom), 0, clr);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    src.source_valid = 1'b1; src.source_sop = 1'b0; src.source_eop = 1'b0;
    src.source_error = 2'b00; frame_ack = 1'b0; err_clr = 1'b0;
    @(posedge clk);
    m_hold = 0; m_in = 0; m_bad = 0; m_err = '0; m_cnt = '0; m_len = '0;
    cur.delete(); held.delete();
    #1;
    reset_n = 1'b1;
    chk("rst_ready", src.source_ready, 1'b1);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_err_flags", err_flags, 4'b0000);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_rd_data", rd_data, 0);
  endtask

  // Beat k carries sop at 0 and sop2_at, eop at eop_at, error=01 at err_at.
  task automatic send_frame(input int nb, input int eop_at, input int sop2_at,
                            input int err_at, input bit gaps, input bit kpat);
    logic [DATA_W-1:0] re, im;
    for (int k = 0; k < nb; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle(1, 0);
      re = kpat ? DATA_W'(k)  : DATA_W'($urandom);
      im = kpat ? DATA_W'(-k) : DATA_W'($urandom);
      step(1, (k == 0) || (k == sop2_at), k == eop_at,
           (k == err_at) ? 2'b01 : 2'b00, re, im, 0, 0);
    end
  endtask

  task automatic hold_and_ack(input bit busy_src);
    for (int i = 0; i < 4; i++) begin
      rd_addr = ADDR_W'($urandom_range(0, MAXP - 1));
      step(busy_src, busy_src, 0, 2'b00, DATA_W'($urandom), DATA_W'($urandom), 0, 0);
    end
    rd_addr = ADDR_W'($urandom_range(0, MAXP - 1));
    step(busy_src, busy_src, 0, 2'b00, DATA_W'($urandom), DATA_W'($urandom), 1, 0);
  endtask

  initial begin
    int pts, mode, nb, eop_at, err_at;
    do_reset();

    // Basic 8-point frame, real=k imag=-k
    fftpts_out = 8;
    send_frame(8, 7, -1, -1, 0, 1);
    rd_addr = 3;
    idle(1, 0);
    chk("t1_rd_addr3", rd_data, 32'h0003_FFFD);
    chk("t1_frame_len", frame_len, 8);
    chk("t1_frame_count", frame_count, 1);
    chk("t1_ready_low", src.source_ready, 1'b0);
    hold_and_ack(0);
    chk("t1_ready_after_ack", src.source_ready, 1'b1);

    // Early eop, then a clean frame
    send_frame(8, 5, -1, -1, 0, 0);
    chk("t2_err_len", err_flags, 4'b0001);
    chk("t2_no_frame", frame_valid, 1'b0);
    send_frame(8, 7, -1, -1, 0, 0);
    chk("t2_recapture", frame_valid, 1'b1);
    hold_and_ack(0);
    idle(1, 1);

    // sop repeated on beat 4, then 8 beats ending in eop
    send_frame(12, 11, 4, -1, 0, 1);
    chk("t3_err_sop", err_flags, 4'b0010);
    rd_addr = 0;
    idle(1, 0);
    chk("t3_addr0_beat4", rd_data, 32'h0004_FFFC);
    hold_and_ack(0);
    idle(1, 1);

    // source_error on beat 2
    send_frame(8, 7, -1, 2, 0, 0);
    chk("t4_err_src", err_flags, 4'b0100);
    chk("t4_no_frame", frame_valid, 1'b0);
    idle(1, 1);
    chk("t4_err_clr", err_flags, 4'b0000);

    // Gapped frame, then a second frame stalls against HOLD
    send_frame(8, 7, -1, -1, 1, 0);
    hold_and_ack(1);
    send_frame(8, 7, -1, -1, 1, 0);
    chk("t5_second_frame", frame_valid, 1'b1);
    hold_and_ack(0);

    // Bad point counts and boundaries
    fftpts_out = 0;
    step(1, 1, 1, 2'b00, 16'h1111, 16'h2222, 0, 0);
    chk("t6_pts0", err_flags[3], 1'b1);
    idle(1, 1);
    fftpts_out = MAXP + 1;
    step(1, 1, 0, 2'b00, 16'h3333, 16'h4444, 0, 0);
    chk("t6_pts_over", err_flags, 4'b1000);
    idle(1, 1);
    fftpts_out = MAXP;
    send_frame(MAXP, MAXP - 1, -1, -1, 0, 0);
    chk("t6_pts_max", frame_len, MAXP);
    hold_and_ack(0);
    fftpts_out = 1;
    send_frame(1, 0, -1, -1, 0, 0);
    chk("t6_pts1_eop", frame_valid, 1'b1);
    hold_and_ack(0);
    send_frame(1, -1, -1, -1, 0, 0);
    chk("t6_pts1_no_eop", err_flags, 4'b0001);
    idle(1, 1);

    // Reset on beat 4 of a frame
    fftpts_out = 8;
    send_frame(4, -1, -1, -1, 0, 0);
    do_reset();
    send_frame(8, 7, -1, -1, 0, 0);
    chk("t7_count_after_reset", frame_count, 1);
    hold_and_ack(0);

    // Randomized frames (frame_count wraps through CNT_W=3)
    for (int r = 0; r < 30; r++) begin
      pts = $urandom_range(1, MAXP);
      mode = $urandom_range(0, 5);
      nb = pts; eop_at = pts - 1; err_at = -1;
      if (mode == 3 && pts > 1) eop_at = $urandom_range(0, pts - 2);
      if (mode == 4) err_at = $urandom_range(0, pts - 1);
      if (mode == 5) begin eop_at = -1; nb = pts + 2; end
      fftpts_out = (ADDR_W+1)'(pts);
      if ($urandom_range(0, 9) == 0) fftpts_out = ($urandom_range(0, 1) == 1) ? '0 : (ADDR_W+1)'(MAXP + 1);
      send_frame(nb, eop_at, -1, err_at, $urandom_range(0, 1) == 1, 0);
      if (m_hold) hold_and_ack($urandom_range(0, 1) == 1);
      idle(1, $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
